// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle between the round-robin arbiter and its requesters.
// Active-low names keep the _B suffix used on the physical bus.
interface bus_arbiter_if #(
    parameter int NUM_REQ = 8
);
    logic [NUM_REQ-1:0] REQ_B;
    logic               FRAME_B;
    logic               IRDY_B;
    logic [NUM_REQ-1:0] GNT_B;
    logic [2:0]         owner;
    logic               bus_busy;
    logic               timeout;

    // Requester/bus side: drives requests and bus phase signals.
    modport master (
        output REQ_B, FRAME_B, IRDY_B,
        input  GNT_B, owner, bus_busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  REQ_B, FRAME_B, IRDY_B,
        output GNT_B, owner, bus_busy, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Eight-way round-robin bus arbiter with grant timeout, request withdrawal
// and a one-cycle turnaround between bus tenures. All outputs are registered.
module bus_arbiter #(
    parameter int NUM_REQ     = 8,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rstb,
    bus_arbiter_if.slave bus
);

    if (NUM_REQ != 8) begin : g_bad_num_req
        $error("bus_arbiter: NUM_REQ must be 8");
    end
    if (GNT_TIMEOUT < 2 || GNT_TIMEOUT > 255) begin : g_bad_timeout
        $error("bus_arbiter: GNT_TIMEOUT must be in 2..255");
    end

    localparam logic [7:0] TIMEOUT_LAST = 8'(GNT_TIMEOUT - 1);
    localparam logic [7:0] CNT_MAX      = 8'hFF;
    localparam logic [7:0] GNT_NONE     = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } state_e;

    state_e     state_q;
    logic [7:0] gnt_b_q;
    logic [2:0] owner_q;
    logic [2:0] last_owner_q;
    logic       bus_busy_q;
    logic       timeout_q;
    logic [7:0] cnt_q;

    logic [2:0] winner;
    logic       win_valid;
    logic [2:0] cand;
    logic [7:0] gnt_b_d;

    // Round-robin search: start just after the previous grantee and wrap.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the unassigned paths infer latches.
        winner    = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_owner_q + 3'(k);
            if (!win_valid && !bus.REQ_B[cand]) begin
                winner    = cand;
                win_valid = 1'b1;
            end
        end
        gnt_b_d = ~(8'b0000_0001 << winner);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // last_owner of 7 makes requester 0 the first candidate after reset.
            state_q      <= IDLE;
            gnt_b_q      <= GNT_NONE;
            owner_q      <= '0;
            last_owner_q <= 3'd7;
            bus_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the pre-edge values of the other registers.
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q      <= GRANT;
                        gnt_b_q      <= gnt_b_d;
                        owner_q      <= winner;
                        last_owner_q <= winner;
                        cnt_q        <= '0;
                    end
                end

                GRANT: begin
                    if (bus.FRAME_B && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    // Frame start outranks both timeout and withdrawal.
                    if (!bus.FRAME_B) begin
                        state_q    <= BUSY;
                        gnt_b_q    <= GNT_NONE;
                        bus_busy_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= TURN;
                        gnt_b_q   <= GNT_NONE;
                        timeout_q <= 1'b1;
                    end else if (bus.REQ_B[owner_q]) begin
                        state_q <= TURN;
                        gnt_b_q <= GNT_NONE;
                    end
                end

                BUSY: begin
                    if (bus.FRAME_B && bus.IRDY_B) begin
                        state_q    <= TURN;
                        bus_busy_q <= 1'b0;
                    end
                end

                TURN: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    gnt_b_q <= GNT_NONE;
                end
            endcase
        end
    end

    assign bus.GNT_B    = gnt_b_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = bus_busy_q;
    assign bus.timeout  = timeout_q;

    a_one_cold: assert property (@(posedge clk) disable iff (!rstb)
        $countones(~gnt_b_q) <= 1);

    a_no_grant_busy: assert property (@(posedge clk) disable iff (!rstb)
        bus_busy_q |-> (gnt_b_q == GNT_NONE));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural bus-tenure model.
module tb_bus_arbiter;

    localparam int TMO = 16;

    // Model phases of a bus tenure (independent of the RTL encoding).
    localparam int PH_WAIT  = 0;
    localparam int PH_OFFER = 1;
    localparam int PH_XFER  = 2;
    localparam int PH_GAP   = 3;

    logic clk = 1'b0;
    logic rstb;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    int         m_phase;
    int         m_last;
    int         m_held;
    logic [7:0] e_gnt;
    int         e_owner;
    logic       e_busy;
    logic       e_to;

    logic [7:0] req_r;
    logic [7:0] exp8;
    int         waited;
    int         held;

    bus_arbiter_if #(.NUM_REQ(8)) bus ();

    bus_arbiter #(
        .NUM_REQ    (8),
        .GNT_TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] rq, input int last);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % 8;
            if (rq[idx] == 1'b0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = PH_WAIT;
        m_last  = 7;
        m_held  = 0;
        e_gnt   = 8'hFF;
        e_owner = 0;
        e_busy  = 1'b0;
        e_to    = 1'b0;
    endtask

    // One rising edge of the reference: uses the inputs present at the edge.
    task automatic model_edge();
        logic [7:0] rq;
        int         w;
        rq   = bus.REQ_B;
        e_to = 1'b0;
        case (m_phase)
            PH_WAIT: begin
                w = pick(rq, m_last);
                if (w >= 0) begin
                    e_owner  = w;
                    m_last   = w;
                    e_gnt    = 8'hFF;
                    e_gnt[w] = 1'b0;
                    m_held   = 0;
                    m_phase  = PH_OFFER;
                end
            end
            PH_OFFER: begin
                m_held++;
                if (!bus.FRAME_B) begin
                    e_gnt   = 8'hFF;
                    e_busy  = 1'b1;
                    m_phase = PH_XFER;
                end else if (m_held >= TMO) begin
                    e_gnt   = 8'hFF;
                    e_to    = 1'b1;
                    m_phase = PH_GAP;
                end else if (rq[e_owner]) begin
                    e_gnt   = 8'hFF;
                    m_phase = PH_GAP;
                end
            end
            PH_XFER: begin
                if (bus.FRAME_B && bus.IRDY_B) begin
                    e_busy  = 1'b0;
                    m_phase = PH_GAP;
                end
            end
            default: m_phase = PH_WAIT;
        endcase
    endtask

    task automatic compare_all();
        check("gnt",     bus.GNT_B,    e_gnt);
        check("owner",   bus.owner,    e_owner);
        check("busy",    bus.bus_busy, e_busy);
        check("timeout", bus.timeout,  e_to);
        check("onecold", ($countones(~bus.GNT_B) <= 1), 1);
    endtask

    // Advance one clock, update the model at the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rstb) model_reset();
        else       model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rstb        = 1'b0;
        bus.REQ_B   = 8'hFF;
        bus.FRAME_B = 1'b1;
        bus.IRDY_B  = 1'b1;
        model_reset();
        step();
        step();
        rstb = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then requesters 0 and 7: 0 wins right after reset.
        do_reset();
        check("rst.gnt",   bus.GNT_B, 8'hFF);
        check("rst.owner", bus.owner, 0);
        bus.REQ_B = 8'h7E;
        step();
        check("r030.gnt",   bus.GNT_B, 8'hFE);
        check("r030.owner", bus.owner, 0);
        bus.REQ_B = 8'hFF;
        step();
        step();
        step();
        check("idle.no_park", bus.GNT_B, 8'hFF);

        // All requesting, one short transfer each: grants rotate 0..7,0.
        do_reset();
        bus.REQ_B = 8'h00;
        for (int g = 0; g < 9; g++) begin
            waited = 0;
            while (bus.GNT_B == 8'hFF && waited < 6) begin
                step();
                waited++;
            end
            exp8        = 8'hFF;
            exp8[g % 8] = 1'b0;
            check("r031.gnt",   bus.GNT_B, exp8);
            check("r031.owner", bus.owner, g % 8);
            bus.FRAME_B = 1'b0;
            bus.IRDY_B  = 1'b0;
            step();
            check("r031.len", bus.GNT_B, 8'hFF);
            step();
            bus.FRAME_B = 1'b1;
            bus.IRDY_B  = 1'b1;
        end

        // Requester 3 granted, never starts a frame: timeout after 16 cycles.
        do_reset();
        bus.REQ_B = 8'hE7;
        step();
        check("r032.gnt", bus.GNT_B, 8'hF7);
        held = 0;
        while (bus.GNT_B == 8'hF7 && held < 40) begin
            held++;
            step();
        end
        check("r032.held",  held, TMO);
        check("r032.pulse", bus.timeout, 1);
        step();
        check("r032.pulse_end", bus.timeout, 0);
        step();
        check("r032.next",  bus.GNT_B, 8'hEF);
        check("r032.owner", bus.owner, 4);

        // Requester 5 withdraws two cycles after its grant; 6 waits.
        do_reset();
        bus.REQ_B = 8'hDF;
        step();
        check("r033.gnt", bus.GNT_B, 8'hDF);
        step();
        step();
        bus.REQ_B = 8'hBF;
        step();
        check("r033.rel", bus.GNT_B, 8'hFF);
        check("r033.to",  bus.timeout, 0);
        step();
        check("r033.turn", bus.GNT_B, 8'hFF);
        step();
        check("r033.regrant", bus.GNT_B, 8'hBF);

        // BUSY held by IRDY_B after FRAME_B rises; requests ignored meanwhile.
        do_reset();
        bus.REQ_B = 8'hFE;
        step();
        bus.FRAME_B = 1'b0;
        bus.IRDY_B  = 1'b0;
        step();
        check("r034.busy", bus.bus_busy, 1);
        bus.FRAME_B = 1'b1;
        bus.REQ_B   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r034.hold", bus.bus_busy, 1);
            check("r034.nognt", bus.GNT_B, 8'hFF);
        end
        bus.IRDY_B = 1'b1;
        step();
        check("r034.exit", bus.bus_busy, 0);
        step();
        check("r034.turn", bus.GNT_B, 8'hFF);
        step();
        check("r034.next", bus.GNT_B, 8'hFD);

        // Asynchronous reset in the middle of a BUSY tenure owned by 1.
        do_reset();
        bus.REQ_B = 8'hFD;
        step();
        bus.FRAME_B = 1'b0;
        bus.IRDY_B  = 1'b0;
        step();
        check("r035.pre_busy", bus.bus_busy, 1);
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        check("r035.gnt",   bus.GNT_B,    8'hFF);
        check("r035.busy",  bus.bus_busy, 0);
        check("r035.owner", bus.owner,    0);
        bus.REQ_B   = 8'hFC;
        bus.FRAME_B = 1'b1;
        bus.IRDY_B  = 1'b1;
        step();
        rstb = 1'b1;
        step();
        check("r035.first", bus.GNT_B, 8'hFE);

        // Randomized traffic: sticky requests, bursts of quiet bus for timeouts.
        do_reset();
        req_r = 8'hFF;
        for (int c = 0; c < 1500; c++) begin
            if ((c % 200) >= 40) begin
                for (int b = 0; b < 8; b++) begin
                    if ($urandom_range(7) == 0) req_r[b] = ~req_r[b];
                end
                bus.FRAME_B = ($urandom_range(9) != 0);
                bus.IRDY_B  = ($urandom_range(3) != 0);
            end else begin
                bus.FRAME_B = 1'b1;
                bus.IRDY_B  = 1'b1;
                if (req_r == 8'hFF) req_r[$urandom_range(7)] = 1'b0;
            end
            bus.REQ_B = req_r;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
